hilo_divider: RTL and testbench

- Iterative radix-2 restoring divider for MIPS DIV/DIVU, in the EX stage beside the ALU.
- Produces quotient for LO and remainder for HI, which the HI/LO register then consumes.
- Holds EX via busy for the length of the operation.
- Accepts a flush (annul) from the exception unit.

---
 rtl/hilo_divider_pkg.sv | 23 ++
 rtl/hilo_div_sign_adj.sv | 40 ++++
 rtl/hilo_divider.sv | 147 ++++++++++++++
 tb/tb_hilo_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hilo_divider_pkg.sv
// Shared definitions for the HI/LO iterative divider: state encoding, widths, decode op codes.
package hilo_divider_pkg;

   localparam int unsigned DIV_WIDTH = 32;
   localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } div_state_e;

   // MIPS SPECIAL funct codes that decode maps onto start/is_signed
   typedef enum logic [5:0] {
      ALU_OP_DIV  = 6'h1A,
      ALU_OP_DIVU = 6'h1B
   } div_alu_op_e;

   function automatic logic alu_op_is_signed(input div_alu_op_e op);
      return (op == ALU_OP_DIV);
   endfunction

endpackage

// File: rtl/hilo_div_sign_adj.sv
// Combinational sign handling for hilo_divider: operand magnitudes on entry,
// result negation and zero-divisor override on exit.
module hilo_div_sign_adj
   import hilo_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             i_is_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_qneg,
   input  logic             i_rneg,
   input  logic             i_dvz,
   output logic [WIDTH-1:0] o_abs_dvd,
   output logic [WIDTH-1:0] o_abs_dvs,
   output logic             o_qneg,
   output logic             o_rneg,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   logic w_dvd_neg;
   logic w_dvs_neg;

   assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
   assign w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];

   // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude
   assign o_abs_dvd = w_dvd_neg ? (~i_dividend + WIDTH'(1)) : i_dividend;
   assign o_abs_dvs = w_dvs_neg ? (~i_divisor + WIDTH'(1)) : i_divisor;
   assign o_qneg    = w_dvd_neg ^ w_dvs_neg;
   assign o_rneg    = w_dvd_neg;

   // With a zero divisor the restoring loop leaves |dividend| in rem, so only the quotient needs forcing
   assign o_quotient  = i_dvz  ? '1 : (i_qneg ? (~i_quo + WIDTH'(1)) : i_quo);
   assign o_remainder = i_rneg ? (~i_rem + WIDTH'(1)) : i_rem;

endmodule

// File: rtl/hilo_divider.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional macro HILO_DIV_ZERO_FAST_EN: zero divisor completes in a single cycle.
module hilo_divider
   import hilo_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             annul,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   div_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_rem;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_dvz;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;

   logic [WIDTH-1:0] w_abs_dvd;
   logic [WIDTH-1:0] w_abs_dvs;
   logic             w_qneg;
   logic             w_rneg;
   logic             w_dvs_zero;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quotient;
   logic [WIDTH-1:0] w_remainder;

   assign w_dvs_zero = (divisor == '0);

   // One restoring step: shift {rem,quo} left, subtract divisor, restore on borrow
   assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
   assign w_rem_nxt = w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

   hilo_div_sign_adj #(.WIDTH(WIDTH)) u_sign_adj (
      .i_is_signed (is_signed),
      .i_dividend  (dividend),
      .i_divisor   (divisor),
      .i_quo       (w_quo_nxt),
      .i_rem       (w_rem_nxt),
      .i_qneg      (r_qneg),
      .i_rneg      (r_rneg),
      .i_dvz       (r_dvz),
      .o_abs_dvd   (w_abs_dvd),
      .o_abs_dvs   (w_abs_dvs),
      .o_qneg      (w_qneg),
      .o_rneg      (w_rneg),
      .o_quotient  (w_quotient),
      .o_remainder (w_remainder)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_dvs       <= '0;
         r_quo       <= '0;
         r_rem       <= '0;
         r_qneg      <= 1'b0;
         r_rneg      <= 1'b0;
         r_dvz       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else if (annul) begin
         // Abort wins over everything; result registers keep the last completed operation
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_dvs  <= w_abs_dvs;
                  r_quo  <= w_abs_dvd;
                  r_rem  <= '0;
                  r_cnt  <= '0;
                  r_qneg <= w_qneg;
                  r_rneg <= w_rneg;
                  r_dvz  <= w_dvs_zero;
                  r_busy <= 1'b1;
`ifdef HILO_DIV_ZERO_FAST_EN
                  if (w_dvs_zero) begin
                     r_quotient  <= '1;
                     r_remainder <= dividend;
                     r_done      <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_state <= S_RUN;
                  end
`else
                  r_state <= S_RUN;
`endif
               end
            end
            S_RUN: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(WIDTH - 1)) begin
                  r_quotient  <= w_quotient;
                  r_remainder <= w_remainder;
                  r_done      <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;

endmodule

// File: tb/tb_hilo_divider.sv
// Self-checking bench for hilo_divider: directed MIPS corner cases plus random DIV/DIVU
// against an arithmetic reference model; honours HILO_DIV_ZERO_FAST_EN for latency.
module tb_hilo_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        annul;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int n_checks = 0;
   int n_errors = 0;

   hilo_divider #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_signed (is_signed),
      .dividend  (dividend),
      .divisor   (divisor),
      .annul     (annul),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // MIPS semantics: truncating division, remainder takes the dividend's sign
   function automatic void model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!sg) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end
   endfunction

   // Launch in cycle 0 and follow the operation to its done pulse, checking busy and latency
   task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input bit noise);
      logic [31:0] eq;
      logic [31:0] er;
      int          cyc;
      int          lat;
      model(sg, a, b, eq, er);
      lat = 33;
`ifdef HILO_DIV_ZERO_FAST_EN
      if (b == 32'd0) lat = 1;
`endif
      @(negedge clk);
      start = 1'b1; is_signed = sg; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 80) begin
         chk("busy_run", 32'(busy), 32'd1);
         @(negedge clk);
         cyc++;
         start = noise && (cyc < lat) && ($urandom_range(0, 2) == 0);
         if (start) begin
            is_signed = $urandom_range(0, 1) == 1;
            dividend  = $urandom;
            divisor   = $urandom;
         end
      end
      start = 1'b0;
      chk("latency", 32'(cyc), 32'(lat));
      chk("busy_done", 32'(busy), 32'd1);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("q_hold", quotient, eq);
      chk("r_hold", remainder, er);
   endtask

   initial begin
      logic [31:0] specials [6];
      logic [31:0] a;
      logic [31:0] b;
      specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'd0;
      specials[3] = 32'd1;         specials[4] = 32'h7FFF_FFFF; specials[5] = 32'd3;

      rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0; annul = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_q", quotient, 32'd0);
      chk("rst_r", remainder, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(1'b0, 32'd100, 32'd7, 1'b0);

      // Annul in cycle 10 of DIVU 9/3: no done, results keep 14/2
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         chk("annul_nodone", 32'(done), 32'd0);
         @(negedge clk);
      end
      annul = 1'b1;
      @(negedge clk);
      annul = 1'b0;
      chk("annul_busy", 32'(busy), 32'd0);
      chk("annul_done", 32'(done), 32'd0);
      chk("annul_q", quotient, 32'd14);
      chk("annul_r", remainder, 32'd2);
      run_op(1'b0, 32'd9, 32'd3, 1'b0);

      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(1'b0, 32'd5, 32'd0, 1'b0);
      run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
      run_op(1'b1, 32'd1000, 32'd33, 1'b1);

      // start together with annul in IDLE launches nothing
      @(negedge clk);
      start = 1'b1; annul = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd0;
      @(negedge clk);
      start = 1'b0; annul = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("sa_busy", 32'(busy), 32'd0);
         chk("sa_done", 32'(done), 32'd0);
         @(negedge clk);
      end

      // Asynchronous reset mid-RUN clears everything without waiting for a clock
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_q", quotient, 32'd0);
      chk("mrst_r", remainder, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         chk("mrst_nodone", 32'(done), 32'd0);
         @(negedge clk);
      end

      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(1, 300));
         run_op($urandom_range(0, 1) == 1, a, b, $urandom_range(0, 3) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
